// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared constants, FSM state type and nibble-count helper for the sequential CLA adder
package cla_seq_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice
//   A, B : nibble operands   Cin : carry in
//   S    : nibble sum        Co  : carry out
module cla4_slice (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Co
);
    logic [3:0] p, g;
    logic [4:0] c;
    assign p = A ^ B;
    assign g = A & B;
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);
    assign S  = p ^ c[3:0];
    assign Co = c[4];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: wide adder that reuses one 4-bit CLA slice over WIDTH/4 cycles, LSB nibble first
//   in_valid/in_ready, a, b, cin : operand handshake, sampled on accept (IDLE only)
//   op_sub                       : subtract select, present only when CLA_SEQ_SUB_EN is defined
//   out_valid/out_ready          : result handshake (DONE only)
//   sum, cout                    : registered result and carry out of the MSB nibble
//   busy                         : high in RUN or DONE
module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIB = nib_count(WIDTH);
    localparam int IW = $clog2(NIB);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic [3:0]       s_nib, b_nib;
    logic             co;

`ifdef CLA_SEQ_SUB_EN
    logic sub_q, sub_d;
    assign b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
`else
    assign b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
`endif

    cla4_slice u_slice (
        .A  (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
        .B  (b_nib),
        .Cin(c_q),
        .S  (s_nib),
        .Co (co)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        c_d     = c_q;
        cout_d  = cout_q;
`ifdef CLA_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                idx_d   = '0;
                sum_d   = '0;
                state_d = ST_RUN;
`ifdef CLA_SEQ_SUB_EN
                // subtraction is A + ~B + 1, so the initial carry is forced high
                sub_d   = op_sub;
                c_d     = op_sub | cin;
`else
                c_d     = cin;
`endif
            end
            ST_RUN: begin
                sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = s_nib;
                c_d     = co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
`ifdef CLA_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb_cla_seq_adder_ctrl: directed and random self-checking bench for cla_seq_adder_ctrl (WIDTH=16)
module tb_cla_seq_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    int          passed = 0;
    int          total = 0;
    int          viol = 0;

    cla_seq_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
`ifdef CLA_SEQ_SUB_EN
        .op_sub(op_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // accepting while busy would show up as in_ready and busy together
    always @(negedge clk) if (!rst && in_ready && busy) viol <= viol + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // one full directed operation with latency and handoff checks
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic ts, input logic [16:0] exp);
        a = ta; b = tb; cin = tc; op_sub = ts; in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("sum_cleared", 32'(sum), 32'd0);
        check("busy_run", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_early_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("valid_at_t4", 32'(out_valid), 32'd1);
        check("result", 32'({cout, sum}), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_idle", 32'({out_valid, busy, in_ready}), 32'b001);
        check("sum_held", 32'(sum), 32'(exp[15:0]));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({out_valid, busy, cout}), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000);
        do_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 17'h0BCDF);
        do_op(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 17'h0FFFF);

        // stall in DONE with a competing request that must be ignored
        a = 16'h00F0; b = 16'h0F10; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_result", 32'({cout, sum}), 32'h01000);
            check("stall_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_release", 32'({out_valid, in_ready}), 32'b01);

        // reset in the middle of RUN discards the operation
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_run", 32'({out_valid, busy, sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(16'h0102, 16'h0304, 1'b1, 1'b0, 17'h00407);

`ifdef CLA_SEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002);
`endif

        // random ops with stalls on both handshakes
        op_sub = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            a = ra; b = rb; cin = rc; in_valid = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 20 && !out_valid; k++) begin
                in_valid = 1'($urandom);
                a = 16'($urandom);
                out_ready = 1'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            if (!out_valid) check("rand_timeout", 32'(out_valid), 32'd1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rand_result", 32'({cout, sum}), 32'({1'b0, ra} + {1'b0, rb} + 17'(rc)));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("no_accept_busy", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
